// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives a framed byte stream over an 8N1 UART and writes
// it into the instruction/data RAM from address 0 upward, holding the CPU
// halted during the transfer and pulsing cpu_start once a frame completes.
// Frame: 0x55 header, LEN byte (0 means 256), LEN data bytes, optional checksum.
// Optional feature macro: UART_LOADER_CSUM_EN (adds the trailing checksum byte,
// sum8 = LEN + data bytes mod 256, and the CSUM state that verifies it).
module uart_prog_loader #(
    parameter int CLK_HZ      = 27_000_000,
    parameter int BAUD        = 115_200,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = CLK_HZ / 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic              we,
    output logic [ADDR_W-1:0] w_addr,
    output logic [7:0]        w_data,
    output logic              cpu_halt,
    output logic              cpu_start,
    output logic              err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
    localparam int BIT_CNT_W    = $clog2(CLKS_PER_BIT + 1);
    localparam int IDLE_CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int LEN_W        = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
    localparam int MAX_LEN      = 1 << ADDR_W;

    localparam logic [BIT_CNT_W-1:0]  BIT_LAST     = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0]  HALF_LAST    = BIT_CNT_W'(HALF_BIT - 1);
    localparam logic [IDLE_CNT_W-1:0] TIMEOUT_LAST = IDLE_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [LEN_W-1:0]      LEN_CAP      = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rxState_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
`ifdef UART_LOADER_CSUM_EN
        ST_CSUM,
`endif
        ST_DONE,
        ST_ABORT
    } state_e;

    // Receiver signals
    logic                 rxMeta_q, rxSync_q, rxPrev_q;
    rxState_e             rxState_q, rxState_d;
    logic [BIT_CNT_W-1:0] bitClk_q, bitClk_d;
    logic [2:0]           bitIdx_q, bitIdx_d;
    logic [7:0]           shift_q, shift_d;
    logic                 byteValid_q, byteValid_d;
    logic                 frameErr_q, frameErr_d;

    // Loader signals
    state_e                state_q, state_d;
    logic [LEN_W-1:0]      len_q, len_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;
    logic [LEN_W-1:0]      cntNext;
    logic [LEN_W-1:0]      lenDecoded;
    logic [IDLE_CNT_W-1:0] idleCnt_q, idleCnt_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     wAddr_q, wAddr_d;
    logic [7:0]            wData_q, wData_d;
    logic                  halt_q, halt_d;
    logic                  start_q, start_d;
    logic                  err_q, err_d;
`ifdef UART_LOADER_CSUM_EN
    logic [7:0]            sum_q, sum_d;
`endif

    assign cntNext = cnt_q + LEN_W'(1);

    // Two-flop synchronizer plus one history flop for start-bit edge detection; idles high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    // Receiver state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxState_q   <= RX_IDLE;
            bitClk_q    <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            byteValid_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            rxState_q   <= rxState_d;
            bitClk_q    <= bitClk_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            byteValid_q <= byteValid_d;
            frameErr_q  <= frameErr_d;
        end
    end

    // Receiver: mid-bit sampling, glitch rejection on the start bit, stop-bit check
    always_comb begin
        rxState_d   = rxState_q;
        bitClk_d    = bitClk_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        byteValid_d = 1'b0;
        frameErr_d  = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                bitClk_d = '0;
                bitIdx_d = '0;
                if (rxPrev_q && !rxSync_q) begin
                    rxState_d = RX_START;
                end
            end
            RX_START: begin
                if (bitClk_q == HALF_LAST) begin
                    bitClk_d  = '0;
                    rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
                end else begin
                    bitClk_d = bitClk_q + BIT_CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (bitClk_q == BIT_LAST) begin
                    bitClk_d = '0;
                    shift_d  = {rxSync_q, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        rxState_d = RX_STOP;
                    end
                end else begin
                    bitClk_d = bitClk_q + BIT_CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (bitClk_q == BIT_LAST) begin
                    bitClk_d    = '0;
                    byteValid_d = rxSync_q;
                    frameErr_d  = !rxSync_q;
                    rxState_d   = RX_IDLE;
                end else begin
                    bitClk_d = bitClk_q + BIT_CNT_W'(1);
                end
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // LEN byte decode: 0 stands for 256, and never more than the RAM holds
    always_comb begin
        lenDecoded = (shift_q == 8'h00) ? LEN_W'(256) : LEN_W'(shift_q);
        if (lenDecoded > LEN_CAP) begin
            lenDecoded = LEN_CAP;
        end
    end

    // Loader state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            len_q     <= '0;
            cnt_q     <= '0;
            idleCnt_q <= '0;
            we_q      <= 1'b0;
            wAddr_q   <= '0;
            wData_q   <= '0;
            halt_q    <= 1'b0;
            start_q   <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_LOADER_CSUM_EN
            sum_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            idleCnt_q <= idleCnt_d;
            we_q      <= we_d;
            wAddr_q   <= wAddr_d;
            wData_q   <= wData_d;
            halt_q    <= halt_d;
            start_q   <= start_d;
            err_q     <= err_d;
`ifdef UART_LOADER_CSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    // Frame parser: header hunt, length, data writes, optional checksum, timeout/abort
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        idleCnt_d = '0;
        we_d      = 1'b0;
        wAddr_d   = wAddr_q;
        wData_d   = wData_q;
        halt_d    = halt_q;
        start_d   = 1'b0;
        err_d     = err_q;
`ifdef UART_LOADER_CSUM_EN
        sum_d     = sum_q;
`endif
        if (state_q != ST_IDLE && state_q != ST_DONE && state_q != ST_ABORT && !byteValid_q) begin
            idleCnt_d = idleCnt_q + IDLE_CNT_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (byteValid_q && shift_q == 8'h55) begin
                    state_d = ST_LEN;
                    err_d   = 1'b0;
                    halt_d  = 1'b1;
                end
            end
            ST_LEN: begin
                if (frameErr_q || (!byteValid_q && idleCnt_q == TIMEOUT_LAST)) begin
                    state_d = ST_ABORT;
                end else if (byteValid_q) begin
                    len_d   = lenDecoded;
                    cnt_d   = '0;
                    state_d = ST_DATA;
`ifdef UART_LOADER_CSUM_EN
                    sum_d   = shift_q;
`endif
                end
            end
            ST_DATA: begin
                if (frameErr_q || (!byteValid_q && idleCnt_q == TIMEOUT_LAST)) begin
                    state_d = ST_ABORT;
                end else if (byteValid_q) begin
                    we_d    = 1'b1;
                    wAddr_d = cnt_q[ADDR_W-1:0];
                    wData_d = shift_q;
                    cnt_d   = cntNext;
`ifdef UART_LOADER_CSUM_EN
                    sum_d   = sum_q + shift_q;
                    if (cntNext == len_q) begin
                        state_d = ST_CSUM;
                    end
`else
                    if (cntNext == len_q) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
`ifdef UART_LOADER_CSUM_EN
            ST_CSUM: begin
                if (frameErr_q || (!byteValid_q && idleCnt_q == TIMEOUT_LAST)) begin
                    state_d = ST_ABORT;
                end else if (byteValid_q) begin
                    state_d = (shift_q == sum_q) ? ST_DONE : ST_ABORT;
                end
            end
`endif
            ST_DONE: begin
                start_d = 1'b1;
                halt_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ABORT: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign we        = we_q;
    assign w_addr    = wAddr_q;
    assign w_data    = wData_q;
    assign cpu_halt  = halt_q;
    assign cpu_start = start_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: table-driven and randomized bench for uart_prog_loader.
// Frames are serialized 8N1 at 10 clocks per bit; expected RAM writes, start
// pulses and err/halt levels come from a frame-level model of the byte stream.
// Follows UART_LOADER_CSUM_EN the same way the design does.
module tb_uart_prog_loader;

    localparam int CLK_HZ      = 1_000_000;
    localparam int BAUD        = 100_000;
    localparam int ADDR_W      = 8;
    localparam int TIMEOUT_CYC = 500;
    localparam int BIT_CLKS    = CLK_HZ / BAUD;
    localparam int SETTLE_CLKS = 650;
`ifdef UART_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct {
        int          n;
        logic [63:0] bytes;
        int          badStop;
        int          expWe;
        int          expStart;
        logic        expErr;
        logic        expHalt;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              rx = 1'b1;
    logic              we;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_data;
    logic              cpu_halt;
    logic              cpu_start;
    logic              err;

    int checks = 0;
    int failures = 0;

    logic [15:0] obsWrites[$];
    int          obsStarts = 0;
    int          haltCycles = 0;

    logic [15:0] expWrites[$];
    int          expStartDelta;
    logic        expErr = 1'b0;
    logic        expHalt = 1'b0;
    bit          sawHeader;

    uart_prog_loader #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx(rx),
        .we(we),
        .w_addr(w_addr),
        .w_data(w_data),
        .cpu_halt(cpu_halt),
        .cpu_start(cpu_start),
        .err(err)
    );

    // 10 ns system clock
    always #5 clk = ~clk;

    // Observe RAM writes, start pulses and halted cycles away from the active edge
    always @(negedge clk) begin
        if (we) obsWrites.push_back({w_addr, w_data});
        if (cpu_start) obsStarts++;
        if (cpu_halt) haltCycles++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic holdBit();
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit goodStop);
        @(posedge clk);
        #1;
        rx = 1'b0;
        holdBit();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            holdBit();
        end
        rx = goodStop;
        holdBit();
        if (!goodStop) begin
            rx = 1'b1;
            holdBit();
        end
    endtask

    task automatic applyStimulus(input logic [7:0] seq[$], input int badStop);
        for (int i = 0; i < seq.size(); i++) begin
            sendByte(seq[i], i != badStop);
        end
    endtask

    // Frame-level model: scan for headers, take LEN and data, verify sum, decide outcome
    task automatic modelSequence(input logic [7:0] seq[$], input int badStop);
        int   pos;
        int   n;
        int   sum;
        bit   ok;
        expWrites.delete();
        expStartDelta = 0;
        sawHeader = 1'b0;
        pos = 0;
        while (pos < seq.size()) begin
            if (pos == badStop || seq[pos] != 8'h55) begin
                pos++;
                continue;
            end
            sawHeader = 1'b1;
            expErr = 1'b0;
            expHalt = 1'b1;
            pos++;
            ok = 1'b1;
            if (pos >= seq.size() || pos == badStop) begin
                ok = 1'b0;
            end else begin
                n = (seq[pos] == 8'h00) ? 256 : int'(seq[pos]);
                if (n > (1 << ADDR_W)) n = 1 << ADDR_W;
                sum = int'(seq[pos]);
                pos++;
                for (int i = 0; i < n && ok; i++) begin
                    if (pos >= seq.size() || pos == badStop) begin
                        ok = 1'b0;
                    end else begin
                        expWrites.push_back({8'(i), seq[pos]});
                        sum += int'(seq[pos]);
                        pos++;
                    end
                end
                if (ok && CSUM_EN) begin
                    if (pos >= seq.size() || pos == badStop || seq[pos] != 8'(sum % 256)) ok = 1'b0;
                    if (pos != badStop) pos++;
                end
            end
            if (ok) begin
                expStartDelta++;
                expHalt = 1'b0;
            end else begin
                expErr = 1'b1;
                if (pos == badStop) pos++;
            end
        end
    endtask

    task automatic runCase(input string name, input logic [7:0] seq[$], input int badStop,
                           input bit useTable, input int tWe, input int tStart,
                           input logic tErr, input logic tHalt);
        int baseW;
        int baseS;
        int baseH;
        baseW = obsWrites.size();
        baseS = obsStarts;
        baseH = haltCycles;
        modelSequence(seq, badStop);
        applyStimulus(seq, badStop);
        repeat (SETTLE_CLKS) @(posedge clk);
        @(negedge clk);
        checkOutput({name, " we_count"}, obsWrites.size() - baseW, expWrites.size());
        for (int i = 0; i < expWrites.size() && baseW + i < obsWrites.size(); i++) begin
            checkOutput({name, " write"}, obsWrites[baseW + i], expWrites[i]);
        end
        checkOutput({name, " start_pulses"}, obsStarts - baseS, expStartDelta);
        checkOutput({name, " err"}, err, expErr);
        checkOutput({name, " halt"}, cpu_halt, expHalt);
        checkOutput({name, " halt_seen"}, (haltCycles > baseH) ? 1 : 0, sawHeader ? 1 : 0);
        if (expWrites.size() > 0) begin
            checkOutput({name, " addr_data_hold"}, {w_addr, w_data}, expWrites[expWrites.size() - 1]);
        end
        if (useTable) begin
            checkOutput({name, " tbl_we"}, obsWrites.size() - baseW, tWe);
            checkOutput({name, " tbl_start"}, obsStarts - baseS, tStart);
            checkOutput({name, " tbl_err"}, err, tErr);
            checkOutput({name, " tbl_halt"}, cpu_halt, tHalt);
        end
    endtask

    // Main test sequence
    initial begin
        vec_t        vecs[6];
        logic [7:0]  q[$];
        int          baseW;
        int          baseS;
        int          baseH;
        int          n;
        int          bad;
        logic [7:0]  sum;
        logic [7:0]  d;

        vecs[0] = '{6, 64'h55_03_A1_78_66_82, -1, 3, 1, 1'b0, 1'b0};
        vecs[1] = '{5, 64'h55_02_11_22_00, -1, 2, CSUM_EN ? 0 : 1, CSUM_EN, CSUM_EN};
        vecs[2] = '{4, 64'h55_01_7E_7F, -1, 1, 1, 1'b0, 1'b0};
        vecs[3] = '{4, 64'h55_02_10_20, 3, 1, 0, 1'b1, 1'b1};
        vecs[4] = '{5, 64'h33_55_01_7E_7F, 0, 1, 1, 1'b0, 1'b0};
        vecs[5] = '{5, 64'h55_02_55_55_AC, -1, 2, 1, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {we, w_addr, w_data, cpu_halt, cpu_start, err}, 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        for (int v = 0; v < 6; v++) begin
            q.delete();
            for (int i = 0; i < vecs[v].n; i++) begin
                q.push_back(vecs[v].bytes[8 * (vecs[v].n - 1 - i) +: 8]);
            end
            runCase($sformatf("vec%0d", v), q, vecs[v].badStop, 1'b1,
                    vecs[v].expWe, vecs[v].expStart, vecs[v].expErr, vecs[v].expHalt);
        end

        // Short low glitch in IDLE must not be taken as a byte
        baseW = obsWrites.size();
        baseS = obsStarts;
        baseH = haltCycles;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        checkOutput("glitch writes", obsWrites.size() - baseW, 0);
        checkOutput("glitch starts", obsStarts - baseS, 0);
        checkOutput("glitch halt", haltCycles - baseH, 0);
        checkOutput("glitch err", err, 0);

        // Timeout: frame stalls after one data byte
        baseW = obsWrites.size();
        baseS = obsStarts;
        q = {8'h55, 8'h02, 8'hAA};
        applyStimulus(q, -1);
        repeat (400) @(posedge clk);
        @(negedge clk);
        checkOutput("timeout early_err", err, 0);
        checkOutput("timeout early_halt", cpu_halt, 1);
        repeat (200) @(posedge clk);
        @(negedge clk);
        checkOutput("timeout err", err, 1);
        checkOutput("timeout halt", cpu_halt, 1);
        checkOutput("timeout writes", obsWrites.size() - baseW, 1);
        if (obsWrites.size() > baseW) checkOutput("timeout write0", obsWrites[baseW], 16'h00AA);
        checkOutput("timeout starts", obsStarts - baseS, 0);
        expErr = 1'b1;
        expHalt = 1'b1;

        // LEN=0 means 256 bytes: addresses 00..FF exactly once
        q.delete();
        q.push_back(8'h55);
        q.push_back(8'h00);
        sum = 8'h00;
        for (int i = 0; i < 256; i++) begin
            d = 8'($urandom_range(0, 255));
            q.push_back(d);
            sum = sum + d;
        end
        if (CSUM_EN) q.push_back(sum);
        runCase("len256", q, -1, 1'b1, 256, 1, 1'b0, 1'b0);

        // Randomized frames: junk, corrupted sums, truncation, bad stop bits
        for (int r = 0; r < 8; r++) begin
            q.delete();
            n = $urandom_range(0, 2);
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 8'h54)));
            q.push_back(8'h55);
            n = $urandom_range(1, 5);
            q.push_back(8'(n));
            sum = 8'(n);
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom_range(0, 255));
                q.push_back(d);
                sum = sum + d;
            end
            if (CSUM_EN) begin
                if ($urandom_range(0, 3) == 0) sum = sum ^ 8'h01;
                q.push_back(sum);
            end
            if ($urandom_range(0, 4) == 0) void'(q.pop_back());
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
            runCase($sformatf("rand%0d", r), q, bad, 1'b0, 0, 0, 1'b0, 1'b0);
        end

        // Asynchronous reset in the middle of a data byte
        q = {8'h55, 8'h04, 8'h01, 8'h02};
        applyStimulus(q, -1);
        @(negedge clk);
        checkOutput("midreset halt_before", cpu_halt, 1);
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (25) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset outputs", {we, w_addr, w_data, cpu_halt, cpu_start, err}, 0);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        expErr = 1'b0;
        expHalt = 1'b0;
        repeat (5) @(posedge clk);
        q = {8'h12};
        runCase("stray", q, -1, 1'b1, 0, 0, 1'b0, 1'b0);
        q = {8'h55, 8'h01, 8'h7E, 8'h7F};
        runCase("reload", q, -1, 1'b1, 1, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
